// File: rtl/game_ctrl.sv
// Pong-style game sequencer: start/serve/play/point/pause/game-over flow,
// score keeping and ball launch control, all outputs registered.
module game_ctrl #(
  parameter int WIN_SCORE    = 9,
  parameter int SERVE_FRAMES = 60,
  parameter int POINT_FRAMES = 90
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       start,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  input  logic       miss_l,
  input  logic       miss_r,
  output logic       ball_rst,
  output logic       ball_en,
  output logic       serve_dir,
  output logic [3:0] score_l,
  output logic [3:0] score_r,
  output logic [2:0] state,
  output logic [1:0] winner
);

  localparam int CNT_MAX = (SERVE_FRAMES > POINT_FRAMES) ? SERVE_FRAMES : POINT_FRAMES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] SERVE_LAST = CNT_W'(SERVE_FRAMES - 1);
  localparam logic [CNT_W-1:0] POINT_LAST = CNT_W'(POINT_FRAMES - 1);
  localparam logic [3:0]       WIN        = 4'(WIN_SCORE);
  localparam logic [7:0]       CMD_START  = 8'h53;
  localparam logic [7:0]       CMD_PAUSE  = 8'h50;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    POINT = 3'd3,
    PAUSE = 3'd4,
    OVER  = 3'd5
  } state_t;

  state_t           st_q, st_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ball_rst_d, ball_en_d, serve_dir_d;
  logic [3:0]       score_l_d, score_r_d;
  logic [1:0]       winner_d;
  logic             start_ev, pause_ev;

  function automatic logic [3:0] sat_inc(input logic [3:0] s);
    return (s >= WIN) ? WIN : s + 4'd1;
  endfunction

  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c,
                                               input logic [CNT_W-1:0] last);
    return (c >= last) ? last : c + CNT_W'(1);
  endfunction

  assign start_ev = start | (rx_valid & (rx_data == CMD_START));
  assign pause_ev = rx_valid & (rx_data == CMD_PAUSE);
  assign state    = st_q;

  always_comb begin
    st_d        = st_q;
    cnt_d       = cnt_q;
    ball_rst_d  = 1'b0;
    ball_en_d   = ball_en;
    serve_dir_d = serve_dir;
    score_l_d   = score_l;
    score_r_d   = score_r;
    winner_d    = winner;
    case (st_q)
      IDLE, OVER: begin
        ball_en_d = 1'b0;
        if (start_ev) begin
          st_d        = SERVE;
          score_l_d   = 4'd0;
          score_r_d   = 4'd0;
          winner_d    = 2'b00;
          ball_rst_d  = 1'b1;
          serve_dir_d = 1'b1;
          cnt_d       = '0;
        end
      end
      SERVE: begin
        ball_en_d = 1'b0;
        if (frame_tick) begin
          if (cnt_q == SERVE_LAST) begin
            st_d      = PLAY;
            ball_en_d = 1'b1;
            cnt_d     = '0;
          end else begin
            cnt_d = cnt_inc(cnt_q, SERVE_LAST);
          end
        end
      end
      PLAY: begin
        // A miss outranks a pause request arriving in the same cycle.
        if (miss_l || miss_r) begin
          st_d      = POINT;
          ball_en_d = 1'b0;
          cnt_d     = '0;
          if (miss_l && !miss_r) begin
            score_r_d   = sat_inc(score_r);
            serve_dir_d = 1'b0;
          end else if (miss_r && !miss_l) begin
            score_l_d   = sat_inc(score_l);
            serve_dir_d = 1'b1;
          end
        end else if (pause_ev) begin
          st_d      = PAUSE;
          ball_en_d = 1'b0;
        end
      end
      PAUSE: begin
        if (pause_ev) begin
          st_d      = PLAY;
          ball_en_d = 1'b1;
        end
      end
      POINT: begin
        if (frame_tick) begin
          if (cnt_q == POINT_LAST) begin
            cnt_d = '0;
            if (score_l == WIN) begin
              st_d     = OVER;
              winner_d = 2'b01;
            end else if (score_r == WIN) begin
              st_d     = OVER;
              winner_d = 2'b10;
            end else begin
              st_d       = SERVE;
              ball_rst_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_inc(cnt_q, POINT_LAST);
          end
        end
      end
      default: begin
        st_d      = IDLE;
        cnt_d     = '0;
        ball_en_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q      <= IDLE;
      cnt_q     <= '0;
      ball_rst  <= 1'b0;
      ball_en   <= 1'b0;
      serve_dir <= 1'b0;
      score_l   <= 4'd0;
      score_r   <= 4'd0;
      winner    <= 2'b00;
    end else begin
      st_q      <= st_d;
      cnt_q     <= cnt_d;
      ball_rst  <= ball_rst_d;
      ball_en   <= ball_en_d;
      serve_dir <= serve_dir_d;
      score_l   <= score_l_d;
      score_r   <= score_r_d;
      winner    <= winner_d;
    end
  end

endmodule

// File: tb/tb_game_ctrl.sv
// Bench for game_ctrl: directed vector table with hand-derived expectations,
// then random traffic checked against a countdown-based game model.
module tb_game_ctrl;

  localparam int WIN = 2;
  localparam int SF  = 2;
  localparam int PF  = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_tick = 1'b0, start = 1'b0, rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       miss_l = 1'b0, miss_r = 1'b0;
  logic       ball_rst, ball_en, serve_dir;
  logic [3:0] score_l, score_r;
  logic [2:0] state;
  logic [1:0] winner;

  game_ctrl #(.WIN_SCORE(WIN), .SERVE_FRAMES(SF), .POINT_FRAMES(PF)) dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .start(start),
    .rx_valid(rx_valid), .rx_data(rx_data), .miss_l(miss_l), .miss_r(miss_r),
    .ball_rst(ball_rst), .ball_en(ball_en), .serve_dir(serve_dir),
    .score_l(score_l), .score_r(score_r), .state(state), .winner(winner)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst, start, rxv;
    logic [7:0] rxd;
    logic       ml, mr, tick;
    logic [2:0] st;
    logic [3:0] sl, sr;
    logic [1:0] win;
    logic       en, brst, dir;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference model: game phase plus frames still to wait.
  int m_st = 0, m_timer = 0, m_sl = 0, m_sr = 0, m_win = 0;
  int m_en = 0, m_brst = 0, m_dir = 0;

  function automatic vec_t v(input int r, s, rv, rd, ml, mr, tk,
                             input int st, sl, sr, win, en, brst, dir);
    vec_t x;
    x.rst = 1'(r);  x.start = 1'(s); x.rxv = 1'(rv); x.rxd = 8'(rd);
    x.ml = 1'(ml);  x.mr = 1'(mr);   x.tick = 1'(tk);
    x.st = 3'(st);  x.sl = 4'(sl);   x.sr = 4'(sr);  x.win = 2'(win);
    x.en = 1'(en);  x.brst = 1'(brst); x.dir = 1'(dir);
    return x;
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int st, sl, sr, win, en, brst, dir);
    chk({tag, ".state"},     8'(state),     8'(st));
    chk({tag, ".score_l"},   8'(score_l),   8'(sl));
    chk({tag, ".score_r"},   8'(score_r),   8'(sr));
    chk({tag, ".winner"},    8'(winner),    8'(win));
    chk({tag, ".ball_en"},   8'(ball_en),   8'(en));
    chk({tag, ".ball_rst"},  8'(ball_rst),  8'(brst));
    chk({tag, ".serve_dir"}, 8'(serve_dir), 8'(dir));
  endtask

  task automatic model_update(input logic r, s, rv, input logic [7:0] rd,
                              input logic ml, mr, ft);
    bit sev, pev;
    sev = s || (rv && rd == 8'h53);
    pev = rv && rd == 8'h50;
    if (r) begin
      m_st = 0; m_timer = 0; m_sl = 0; m_sr = 0; m_win = 0;
      m_en = 0; m_brst = 0; m_dir = 0;
    end else begin
      m_brst = 0;
      case (m_st)
        0, 5: if (sev) begin
          m_st = 1; m_sl = 0; m_sr = 0; m_win = 0; m_brst = 1; m_dir = 1;
          m_en = 0; m_timer = SF;
        end
        1: if (ft) begin
          m_timer--;
          if (m_timer == 0) begin m_st = 2; m_en = 1; end
        end
        2: if (ml || mr) begin
          m_st = 3; m_en = 0; m_timer = PF;
          if (ml && !mr) begin m_sr = (m_sr + 1 > WIN) ? WIN : m_sr + 1; m_dir = 0; end
          if (mr && !ml) begin m_sl = (m_sl + 1 > WIN) ? WIN : m_sl + 1; m_dir = 1; end
        end else if (pev) begin
          m_st = 4; m_en = 0;
        end
        4: if (pev) begin m_st = 2; m_en = 1; end
        3: if (ft) begin
          m_timer--;
          if (m_timer == 0) begin
            if (m_sl == WIN)      begin m_st = 5; m_win = 1; end
            else if (m_sr == WIN) begin m_st = 5; m_win = 2; end
            else begin m_st = 1; m_brst = 1; m_timer = SF; end
          end
        end
        default: m_st = 0;
      endcase
    end
  endtask

  task automatic step(input logic r, s, rv, input logic [7:0] rd,
                      input logic ml, mr, ft);
    rst = r; start = s; rx_valid = rv; rx_data = rd;
    miss_l = ml; miss_r = mr; frame_tick = ft;
    @(posedge clk); #1;
    model_update(r, s, rv, rd, ml, mr, ft);
  endtask

  initial begin
    logic prev_brst;
    //              rst st rv rd    ml mr tk   st sl sr w en br dr
    tbl.push_back(v(1, 0, 0, 0,    0, 0, 0,   0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(1, 0, 0, 0,    0, 0, 0,   0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 0,    0, 0, 0,   0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 0,    0, 0, 1,   0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 1, 0, 0,    0, 0, 0,   1, 0, 0, 0, 0, 1, 1));
    tbl.push_back(v(0, 0, 0, 0,    0, 0, 0,   1, 0, 0, 0, 0, 0, 1));
    tbl.push_back(v(0, 0, 0, 0,    0, 0, 1,   1, 0, 0, 0, 0, 0, 1));
    tbl.push_back(v(0, 0, 0, 0,    0, 0, 1,   2, 0, 0, 0, 1, 0, 1));
    tbl.push_back(v(0, 0, 0, 0,    0, 1, 0,   3, 1, 0, 0, 0, 0, 1));
    tbl.push_back(v(0, 0, 0, 0,    0, 0, 1,   3, 1, 0, 0, 0, 0, 1));
    tbl.push_back(v(0, 0, 0, 0,    0, 0, 1,   3, 1, 0, 0, 0, 0, 1));
    tbl.push_back(v(0, 0, 0, 0,    0, 0, 1,   1, 1, 0, 0, 0, 1, 1));
    tbl.push_back(v(0, 1, 0, 0,    0, 0, 0,   1, 1, 0, 0, 0, 0, 1));
    tbl.push_back(v(0, 0, 0, 0,    0, 0, 1,   1, 1, 0, 0, 0, 0, 1));
    tbl.push_back(v(0, 0, 0, 0,    0, 0, 1,   2, 1, 0, 0, 1, 0, 1));
    tbl.push_back(v(0, 0, 0, 0,    0, 1, 0,   3, 2, 0, 0, 0, 0, 1));
    tbl.push_back(v(0, 0, 0, 0,    0, 0, 1,   3, 2, 0, 0, 0, 0, 1));
    tbl.push_back(v(0, 0, 0, 0,    0, 0, 1,   3, 2, 0, 0, 0, 0, 1));
    tbl.push_back(v(0, 0, 0, 0,    0, 0, 1,   5, 2, 0, 1, 0, 0, 1));
    tbl.push_back(v(0, 0, 0, 0,    0, 0, 1,   5, 2, 0, 1, 0, 0, 1));
    tbl.push_back(v(0, 0, 1, 'h53, 0, 0, 0,   1, 0, 0, 0, 0, 1, 1));
    tbl.push_back(v(0, 0, 0, 0,    0, 0, 1,   1, 0, 0, 0, 0, 0, 1));
    tbl.push_back(v(0, 0, 0, 0,    0, 0, 1,   2, 0, 0, 0, 1, 0, 1));
    tbl.push_back(v(0, 0, 0, 0,    1, 1, 0,   3, 0, 0, 0, 0, 0, 1));
    tbl.push_back(v(0, 0, 0, 0,    0, 0, 1,   3, 0, 0, 0, 0, 0, 1));
    tbl.push_back(v(0, 0, 0, 0,    0, 0, 1,   3, 0, 0, 0, 0, 0, 1));
    tbl.push_back(v(0, 0, 0, 0,    0, 0, 1,   1, 0, 0, 0, 0, 1, 1));
    tbl.push_back(v(0, 0, 0, 0,    0, 0, 1,   1, 0, 0, 0, 0, 0, 1));
    tbl.push_back(v(0, 0, 0, 0,    0, 0, 1,   2, 0, 0, 0, 1, 0, 1));
    tbl.push_back(v(0, 0, 1, 'h50, 0, 0, 0,   4, 0, 0, 0, 0, 0, 1));
    tbl.push_back(v(0, 0, 0, 0,    1, 0, 1,   4, 0, 0, 0, 0, 0, 1));
    for (int i = 0; i < 4; i++)
      tbl.push_back(v(0, 0, 0, 0,  0, 0, 1,   4, 0, 0, 0, 0, 0, 1));
    tbl.push_back(v(0, 0, 1, 'h41, 0, 0, 0,   4, 0, 0, 0, 0, 0, 1));
    tbl.push_back(v(0, 0, 1, 'h50, 0, 0, 0,   2, 0, 0, 0, 1, 0, 1));
    tbl.push_back(v(0, 0, 1, 'h50, 1, 0, 0,   3, 0, 1, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 0,    0, 0, 1,   3, 0, 1, 0, 0, 0, 0));
    tbl.push_back(v(1, 0, 0, 0,    0, 0, 1,   0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 0,    0, 0, 0,   0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 1, 1, 'h53, 0, 0, 0,   1, 0, 0, 0, 0, 1, 1));
    tbl.push_back(v(0, 0, 0, 0,    0, 0, 0,   1, 0, 0, 0, 0, 0, 1));
    tbl.push_back(v(0, 0, 1, 'h53, 0, 0, 0,   1, 0, 0, 0, 0, 0, 1));
    tbl.push_back(v(1, 1, 0, 0,    0, 0, 1,   0, 0, 0, 0, 0, 0, 0));

    #1;
    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].start, tbl[i].rxv, tbl[i].rxd,
           tbl[i].ml, tbl[i].mr, tbl[i].tick);
      chk_all($sformatf("vec%0d", i), int'(tbl[i].st), int'(tbl[i].sl), int'(tbl[i].sr),
              int'(tbl[i].win), int'(tbl[i].en), int'(tbl[i].brst), int'(tbl[i].dir));
    end

    step(1, 0, 0, 8'h00, 0, 0, 0);
    prev_brst = ball_rst;
    for (int c = 0; c < 4000; c++) begin
      logic r, s, rv, ml, mr, ft;
      logic [7:0] rd;
      int sel;
      r  = ($urandom_range(0, 299) == 0);
      s  = ($urandom_range(0, 39) == 0);
      rv = ($urandom_range(0, 9) == 0);
      sel = $urandom_range(0, 3);
      rd = (sel == 0) ? 8'h53 : (sel == 1) ? 8'h50 : 8'($urandom_range(0, 255));
      ml = ($urandom_range(0, 14) == 0);
      mr = ($urandom_range(0, 14) == 0);
      ft = ($urandom_range(0, 2) == 0);
      step(r, s, rv, rd, ml, mr, ft);
      chk_all("rand", m_st, m_sl, m_sr, m_win, m_en, m_brst, m_dir);
      chk("rand.ball_rst_double", 8'(prev_brst & ball_rst), 8'd0);
      prev_brst = ball_rst;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/game_ctrl.md
GAME_CTRL -- requirements
Module: game_ctrl

Interface
REQ-001 Parameter WIN_SCORE, default 9: points needed to win; legal range 1..15.
REQ-002 Parameter SERVE_FRAMES, default 60: frames the ball is held before launch.
REQ-003 Parameter POINT_FRAMES, default 90: frames of pause after a point.
REQ-004 Port clk, input, 1: single clock (65 MHz pixel clock); all logic on its rising edge.
REQ-005 Port rst, input, 1: synchronous, active-high reset.
REQ-006 Port frame_tick, input, 1: one-cycle pulse, once per video frame.
REQ-007 Port start, input, 1: one-cycle pulse from the debounced start button.
REQ-008 Port rx_valid, input, 1: one-cycle strobe; rx_data is valid in that cycle.
REQ-009 Port rx_data, input, 8: UART command byte.
REQ-010 Port miss_l / miss_r, input, 1 each: one-cycle pulse; the ball passed the left / right paddle.
REQ-011 Port ball_rst, output, 1: one-cycle pulse that recentres the ball.
REQ-012 Port ball_en, output, 1: level; ball motion enabled.
REQ-013 Port serve_dir, output, 1: launch direction; 0 = toward left, 1 = toward right.
REQ-014 Port score_l / score_r, output, 4 each: current scores, fed to the seven-segment driver.
REQ-015 Port state, output, 3: encoded FSM state.
REQ-016 Port winner, output, 2: 00 = none, 01 = left, 10 = right.

Function
REQ-017 FSM states and encodings: IDLE=0, SERVE=1, PLAY=2, POINT=3, PAUSE=4, OVER=5.
REQ-018 All outputs registered; state changes one clk after the qualifying input.
REQ-019 Start event = start pulse OR (rx_valid AND rx_data==0x53 'S'); both in the same cycle count as one event.
REQ-020 Pause event = rx_valid AND rx_data==0x50 'P'; all other bytes ignored.
REQ-021 IDLE or OVER + start event -> SERVE:
- score_l = score_r = 0, winner = 00
- ball_rst pulses 1 cycle
- serve_dir = 1
- frame counter = 0
REQ-022 Start events in SERVE, PLAY, POINT and PAUSE are ignored.
REQ-023 SERVE:
- ball_en = 0
- frame counter increments per frame_tick
- after SERVE_FRAMES ticks -> PLAY; ball_en = 1 from that same edge
REQ-024 PLAY, miss_l only:
- score_r += 1, serve_dir = 0, ball_en = 0, counter = 0 -> POINT
REQ-025 PLAY, miss_r only:
- score_l += 1, serve_dir = 1, ball_en = 0, counter = 0 -> POINT
REQ-026 PLAY, miss_l AND miss_r in the same cycle: no score change, serve_dir unchanged -> POINT (replay).
REQ-027 PLAY, miss and pause event in the same cycle: the miss wins; the pause event is dropped.
REQ-028 PLAY + pause event -> PAUSE, ball_en = 0; PAUSE + pause event -> PLAY, ball_en = 1.
REQ-029 PAUSE: miss pulses and frame_tick are ignored; scores are held.
REQ-030 POINT:
- counter increments per frame_tick
- after POINT_FRAMES ticks, if a score == WIN_SCORE -> OVER, winner set to that side
- otherwise ball_rst pulses, counter = 0 -> SERVE
REQ-031 Scores saturate at WIN_SCORE and never wrap.
REQ-032 Frame counter width is $clog2(max(SERVE_FRAMES, POINT_FRAMES)+1); it never exceeds its terminal value.
REQ-033 OVER: ball_en = 0; scores and winner held until a start event.
REQ-034 ball_rst is high for exactly one cycle per event and never for two consecutive cycles.

Reset
REQ-035 rst has priority over every input.
REQ-036 Values while rst is high, including mid-play or mid-count:
- state IDLE, counter 0
- ball_rst = 0, ball_en = 0, serve_dir = 0
- score_l = score_r = 0, winner = 00
REQ-037 After rst deasserts, the block stays in IDLE until a start event.

Verification (bench parameters: WIN_SCORE=2, SERVE_FRAMES=2, POINT_FRAMES=3)
REQ-038 Reset, then start pulse -> next cycle: state=1, ball_rst=1 for one cycle; after 2 frame_ticks: state=2, ball_en=1.
REQ-039 In PLAY, miss_r twice, each followed by 3 frame_ticks -> score_l=2, state=5, winner=01, ball_en=0; then rx 'S' -> scores 0, state=1.
REQ-040 In PLAY, miss_l and miss_r in the same cycle -> state=3, scores unchanged, serve_dir unchanged.
REQ-041 In PLAY: rx 'P' -> state=4, ball_en=0; miss_l and 5 frame_ticks -> no change; rx 'P' -> state=2, ball_en=1.
REQ-042 rst asserted mid-POINT with score_r=1 -> next cycle all outputs 0, state=0; start pulse and rx 'S' in the same cycle -> exactly one ball_rst pulse.
